run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_if.sv | 59 +++++
 rtl/run_ctrl.sv | 178 +++++++++++++++++
 tb/tb_run_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_if.sv
// run_ctrl_if -- signal bundle between a run controller and whoever drives it.
//
// Parameter:
//   CW          width of the run cycle counter
//
// Signals:
//   start       run request from the host
//   abort       cancel the current run from the host
//   cpu_halt    program-end level reported by the CPU
//   cpu_rst     active-low reset driven to the CPU
//   cpu_enable  one-cycle kick pulse to the CPU
//   busy        a run is in progress (reset, kick or run phase)
//   done        the last run has finished
//   timeout     the last run was ended by the watchdog
//   cycle_count run cycles of the current or last run
//
// Modports:
//   master      host/testbench side, drives start/abort/cpu_halt
//   slave       controller side, drives the status and CPU control lines

interface run_ctrl_if #(
   parameter int CW = 16
);

   logic          start;
   logic          abort;
   logic          cpu_halt;
   logic          cpu_rst;
   logic          cpu_enable;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [CW-1:0] cycle_count;

   modport master (
      output start,
      output abort,
      output cpu_halt,
      input  cpu_rst,
      input  cpu_enable,
      input  busy,
      input  done,
      input  timeout,
      input  cycle_count
   );

   modport slave (
      input  start,
      input  abort,
      input  cpu_halt,
      output cpu_rst,
      output cpu_enable,
      output busy,
      output done,
      output timeout,
      output cycle_count
   );

endinterface

// File: rtl/run_ctrl.sv
// run_ctrl -- sequences one program run on a CPU: hold the CPU in reset,
// kick it with a single enable pulse, count run cycles until it halts, then
// report the result until the host starts a new run or aborts.
//
// Parameters:
//   RST_CYCLES  cycles the CPU reset is held low per run (1..255)
//   MAX_CYCLES  watchdog limit in run cycles (1..2^CW-1), watchdog build only
//   CW          cycle counter width
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         asynchronous active-low reset
//   bus         run_ctrl_if slave modport (start/abort/cpu_halt in,
//               cpu_rst/cpu_enable/busy/done/timeout/cycle_count out)
//
// Build option:
//   RUN_CTRL_WATCHDOG_EN  when defined, a run that reaches MAX_CYCLES run
//                         cycles without a halt ends with timeout=1. When
//                         undefined there is no watchdog, timeout is tied
//                         low and a run only ends on cpu_halt or abort.

module run_ctrl #(
   parameter int RST_CYCLES = 2,
   parameter int MAX_CYCLES = 1000,
   parameter int CW         = 16
) (
   input logic       clk,
   input logic       rst,
   run_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      RESET,
      KICK,
      RUN,
      DONE
   } state_t;

   localparam logic [CW-1:0] COUNT_MAX = '1;
   localparam logic [7:0]    RST_LAST  = 8'(RST_CYCLES);

   state_t        state;
   state_t        state_next;
   logic [7:0]    rst_cnt;
   logic [7:0]    rst_cnt_next;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [CW-1:0] count_inc;

   logic          cpu_rst_reg;
   logic          cpu_rst_next;
   logic          cpu_enable_reg;
   logic          cpu_enable_next;
   logic          busy_reg;
   logic          busy_next;
   logic          done_reg;
   logic          done_next;

`ifdef RUN_CTRL_WATCHDOG_EN
   localparam logic [CW-1:0] WD_LIMIT = CW'(MAX_CYCLES);

   logic          timeout_reg;
   logic          timeout_next;
`endif

   // State register plus every output flop. Outputs are registered copies
   // of what the next state implies, so nothing combinational reaches a pin.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         rst_cnt        <= 8'd0;
         count          <= '0;
         cpu_rst_reg    <= 1'b0;
         cpu_enable_reg <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
         timeout_reg    <= 1'b0;
`endif
      end else begin
         state          <= state_next;
         rst_cnt        <= rst_cnt_next;
         count          <= count_next;
         cpu_rst_reg    <= cpu_rst_next;
         cpu_enable_reg <= cpu_enable_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
`ifdef RUN_CTRL_WATCHDOG_EN
         timeout_reg    <= timeout_next;
`endif
      end
   end

   // Next-state and next-output logic. Abort beats everything else in every
   // state; in IDLE it simply keeps us in IDLE. The counter saturates rather
   // than wrapping so a very long run still reads as "at least this long".
   always_comb begin
      state_next   = state;
      rst_cnt_next = rst_cnt;
      count_next   = count;
      count_inc    = (count == COUNT_MAX) ? count : count + CW'(1);
`ifdef RUN_CTRL_WATCHDOG_EN
      timeout_next = timeout_reg;
`endif

      unique case (state)
         IDLE, DONE: begin
            if (bus.abort) begin
               state_next   = IDLE;
`ifdef RUN_CTRL_WATCHDOG_EN
               timeout_next = 1'b0;
`endif
            end else if (bus.start) begin
               state_next   = RESET;
               rst_cnt_next = 8'd1;
               count_next   = '0;
`ifdef RUN_CTRL_WATCHDOG_EN
               timeout_next = 1'b0;
`endif
            end
         end

         RESET: begin
            if (bus.abort) begin
               state_next = IDLE;
            end else if (rst_cnt >= RST_LAST) begin
               state_next = KICK;
            end else begin
               rst_cnt_next = rst_cnt + 8'd1;
            end
         end

         KICK: begin
            state_next = bus.abort ? IDLE : RUN;
         end

         RUN: begin
            if (bus.abort) begin
               state_next = IDLE;
            end else begin
               // The cycle in which halt is seen is itself counted.
               count_next = count_inc;
               if (bus.cpu_halt) begin
                  state_next = DONE;
`ifdef RUN_CTRL_WATCHDOG_EN
                  timeout_next = 1'b0;
               end else if (count_inc == WD_LIMIT) begin
                  state_next   = DONE;
                  timeout_next = 1'b1;
`endif
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      cpu_rst_next    = (state_next != RESET);
      cpu_enable_next = (state_next == KICK);
      busy_next       = (state_next == RESET) || (state_next == KICK) || (state_next == RUN);
      done_next       = (state_next == DONE);
   end

   assign bus.cpu_rst     = cpu_rst_reg;
   assign bus.cpu_enable  = cpu_enable_reg;
   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.cycle_count = count;
`ifdef RUN_CTRL_WATCHDOG_EN
   assign bus.timeout     = timeout_reg;
`else
   assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl -- self-checking bench for run_ctrl. Two instances run side by
// side from the same stimulus: one with default parameters, one narrow
// (CW=4, RST_CYCLES=3, MAX_CYCLES=12) to reach counter saturation and the
// watchdog quickly. Every cycle both are compared to a reference model that
// tracks a run by elapsed cycles since its start. Honours
// RUN_CTRL_WATCHDOG_EN the same way the design does.

module tb_run_ctrl;

   localparam int RST_A = 2;
   localparam int MAX_A = 1000;
   localparam int CW_A  = 16;
   localparam int RST_B = 3;
   localparam int MAX_B = 12;
   localparam int CW_B  = 4;

`ifdef RUN_CTRL_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   int check_count = 0;
   int pass_count  = 0;

   run_ctrl_if #(.CW(CW_A)) bus_a ();
   run_ctrl_if #(.CW(CW_B)) bus_b ();

   run_ctrl #(
      .RST_CYCLES(RST_A),
      .MAX_CYCLES(MAX_A),
      .CW        (CW_A)
   ) dut_a (
      .clk(clk),
      .rst(rst),
      .bus(bus_a)
   );

   run_ctrl #(
      .RST_CYCLES(RST_B),
      .MAX_CYCLES(MAX_B),
      .CW        (CW_B)
   ) dut_b (
      .clk(clk),
      .rst(rst),
      .bus(bus_b)
   );

   always #5 clk = ~clk;

   // Reference model: a run is described by how many edges have passed since
   // the start edge. The first RST cycles hold the CPU in reset, the next
   // one is the kick, and every edge after that is one counted run cycle.
   int     m_rst_cycles [2] = '{RST_A, RST_B};
   int     m_max        [2] = '{MAX_A, MAX_B};
   longint m_sat        [2] = '{(64'd1 << CW_A) - 1, (64'd1 << CW_B) - 1};
   bit     m_running    [2];
   bit     m_done       [2];
   bit     m_timeout    [2];
   bit     m_pending    [2];
   int     m_elapsed    [2];
   longint m_count      [2];

   task automatic reset_model(input int d);
      m_running[d] = 1'b0;
      m_done[d]    = 1'b0;
      m_timeout[d] = 1'b0;
      m_pending[d] = 1'b1;
      m_elapsed[d] = 0;
      m_count[d]   = 0;
   endtask

   task automatic step_model(input int d, input bit s, input bit a, input bit h);
      int r;
      m_pending[d] = 1'b0;
      if (m_running[d]) begin
         if (a) begin
            m_running[d] = 1'b0;
            m_done[d]    = 1'b0;
            m_timeout[d] = 1'b0;
         end else if (m_elapsed[d] >= m_rst_cycles[d] + 1) begin
            r = m_elapsed[d] - m_rst_cycles[d];
            m_count[d] = (r > m_sat[d]) ? m_sat[d] : longint'(r);
            if (h) begin
               m_running[d] = 1'b0;
               m_done[d]    = 1'b1;
               m_timeout[d] = 1'b0;
            end else if (WD_EN && r >= m_max[d]) begin
               m_running[d] = 1'b0;
               m_done[d]    = 1'b1;
               m_timeout[d] = 1'b1;
            end else begin
               m_elapsed[d]++;
            end
         end else begin
            m_elapsed[d]++;
         end
      end else if (a) begin
         m_done[d]    = 1'b0;
         m_timeout[d] = 1'b0;
      end else if (s) begin
         m_running[d] = 1'b1;
         m_elapsed[d] = 0;
         m_count[d]   = 0;
         m_done[d]    = 1'b0;
         m_timeout[d] = 1'b0;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else begin
         $error("[TB] FAIL %s @%0t observed=%0d expected=%0d", tag, $time, observed, expected);
      end
   endtask

   task automatic check_dut(input int d, input logic cpu_rst, input logic cpu_enable,
                            input logic busy, input logic done, input logic timeout,
                            input logic [63:0] count);
      bit exp_rst;
      bit exp_en;
      string p;
      p       = (d == 0) ? "a" : "b";
      exp_rst = m_pending[d] ? 1'b0 : (m_running[d] ? (m_elapsed[d] >= m_rst_cycles[d]) : 1'b1);
      exp_en  = !m_pending[d] && m_running[d] && (m_elapsed[d] == m_rst_cycles[d]);
      check({p, " cpu_rst"},     64'(cpu_rst),    64'(exp_rst));
      check({p, " cpu_enable"},  64'(cpu_enable), 64'(exp_en));
      check({p, " busy"},        64'(busy),       64'(m_running[d]));
      check({p, " done"},        64'(done),       64'(m_done[d]));
      check({p, " timeout"},     64'(timeout),    64'(m_timeout[d]));
      check({p, " cycle_count"}, count,           64'(m_count[d]));
   endtask

   task automatic check_output();
      check_dut(0, bus_a.cpu_rst, bus_a.cpu_enable, bus_a.busy, bus_a.done, bus_a.timeout,
                64'(bus_a.cycle_count));
      check_dut(1, bus_b.cpu_rst, bus_b.cpu_enable, bus_b.busy, bus_b.done, bus_b.timeout,
                64'(bus_b.cycle_count));
   endtask

   task automatic drive(input bit s, input bit a, input bit h);
      bus_a.start    = s;
      bus_a.abort    = a;
      bus_a.cpu_halt = h;
      bus_b.start    = s;
      bus_b.abort    = a;
      bus_b.cpu_halt = h;
   endtask

   // One clock cycle: inputs change at the falling edge, the model steps on
   // the rising edge, outputs are compared 1 time unit later.
   task automatic apply_stimulus(input bit s, input bit a, input bit h);
      @(negedge clk);
      drive(s, a, h);
      @(posedge clk);
      step_model(0, s, a, h);
      step_model(1, s, a, h);
      #1;
      check_output();
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      #1;
      check_output();
      @(posedge clk);
      step_model(0, 1'b0, 1'b0, 1'b0);
      step_model(1, 1'b0, 1'b0, 1'b0);
      #1;
      check_output();
   endtask

   // Asserts reset part way through a cycle and checks the outputs respond
   // before the next clock edge, then holds it across one edge and releases.
   task automatic apply_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      reset_model(0);
      reset_model(1);
      #1;
      check_output();
      @(posedge clk);
      #1;
      check_output();
      release_reset();
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0);
      reset_model(0);
      reset_model(1);
      #1;
      check_output();
      check("reset cpu_rst", 64'(bus_a.cpu_rst), 64'd0);
      check("reset count",   64'(bus_a.cycle_count), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      check_output();
      release_reset();
      check("release cpu_rst high", 64'(bus_a.cpu_rst), 64'd1);
      check("release stays idle",   64'(bus_a.busy), 64'd0);

      $display("[TB] abort and start together in IDLE, halt in IDLE");
      apply_stimulus(1'b1, 1'b1, 1'b0);
      check("start+abort idle busy", 64'(bus_a.busy), 64'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b1, 1'b0);

      $display("[TB] start latency and halt after 37 run cycles");
      apply_stimulus(1'b1, 1'b0, 1'b0);
      check("latency rst 1", 64'(bus_a.cpu_rst), 64'd0);
      check("latency busy",  64'(bus_a.busy), 64'd1);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check("latency rst 2", 64'(bus_a.cpu_rst), 64'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check("latency kick",     64'(bus_a.cpu_enable), 64'd1);
      check("latency kick rst", 64'(bus_a.cpu_rst), 64'd1);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      check("kick one cycle", 64'(bus_a.cpu_enable), 64'd0);
      idle_steps(36);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      check("halt37 done",    64'(bus_a.done), 64'd1);
      check("halt37 timeout", 64'(bus_a.timeout), 64'd0);
      check("halt37 count",   64'(bus_a.cycle_count), 64'd37);
      check("halt37 busy",    64'(bus_a.busy), 64'd0);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] start while busy, abort in RUN at count 10");
      apply_stimulus(1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) apply_stimulus(i == 3 || i == 7, 1'b0, 1'b0);
      check("busy start count", 64'(bus_a.cycle_count), 64'd10);
      apply_stimulus(1'b0, 1'b1, 1'b0);
      check("abort count", 64'(bus_a.cycle_count), 64'd10);
      check("abort done",  64'(bus_a.done), 64'd0);
      check("abort busy",  64'(bus_a.busy), 64'd0);

      $display("[TB] reset mid-run at count 12");
      apply_stimulus(1'b1, 1'b0, 1'b0);
      idle_steps(3 + 12);
      check("pre reset count", 64'(bus_a.cycle_count), 64'd12);
      @(negedge clk);
      #2;
      rst = 1'b0;
      reset_model(0);
      reset_model(1);
      #1;
      check("midrun reset cpu_rst", 64'(bus_a.cpu_rst), 64'd0);
      check("midrun reset count",   64'(bus_a.cycle_count), 64'd0);
      check("midrun reset busy",    64'(bus_a.busy), 64'd0);
      check_output();
      release_reset();
      idle_steps(2);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      idle_steps(4);
      check("restart count", 64'(bus_a.cycle_count), 64'd1);
      apply_stimulus(1'b0, 1'b1, 1'b0);

      $display("[TB] narrow instance: run 20 cycles without halt");
      apply_stimulus(1'b1, 1'b0, 1'b0);
      idle_steps(4 + 20);
`ifdef RUN_CTRL_WATCHDOG_EN
      check("wd done",    64'(bus_b.done), 64'd1);
      check("wd timeout", 64'(bus_b.timeout), 64'd1);
      check("wd count",   64'(bus_b.cycle_count), 64'd12);
`else
      check("sat count", 64'(bus_b.cycle_count), 64'd15);
      check("sat busy",  64'(bus_b.busy), 64'd1);
`endif
      apply_stimulus(1'b0, 1'b1, 1'b0);

      $display("[TB] narrow instance: halt on the 12th run cycle");
      apply_stimulus(1'b1, 1'b0, 1'b0);
      idle_steps(4 + 11);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      check("halt12 done",    64'(bus_b.done), 64'd1);
      check("halt12 timeout", 64'(bus_b.timeout), 64'd0);
      check("halt12 count",   64'(bus_b.cycle_count), 64'd12);
      apply_stimulus(1'b0, 1'b1, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            apply_reset();
         end else begin
            apply_stimulus($urandom_range(0, 7) == 0,
                           $urandom_range(0, 39) == 0,
                           $urandom_range(0, 24) == 0);
         end
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
